// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMA channel arbiter.
package dmac_pkg;

  // Arbiter FSM: either waiting to arbitrate or holding a grant.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dmac_state_e;

  // Arbitration mode select values.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Increment a channel index, wrapping at n back to zero.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
  endfunction

endpackage

// File: rtl/dmac_rr_pick.sv
// Rotating priority search: finds the first set request bit at or above
// start_ptr, wrapping from NUM_CH-1 back to 0. A start of 0 gives plain
// lowest-index-wins priority.
module dmac_rr_pick #(
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned ID_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   start_ptr,
  output logic [ID_W-1:0]   index,
  output logic              found
);

  logic [ID_W-1:0] w_pos;

  // Walk the ring once from start_ptr and latch the first requester seen.
  always_comb begin
    index = '0;
    found = 1'b0;
    w_pos = '0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      w_pos = ID_W'((32'(start_ptr) + off) % NUM_CH);
      if (!found && req[w_pos]) begin
        found = 1'b1;
        index = w_pos;
      end
    end
  end

endmodule

// File: rtl/dmac_ch_arbiter.sv
// DMA channel arbiter: grants one of NUM_CH requesting channels in fixed or
// round-robin priority, holds the grant until xfer_done or a hold timeout.
module dmac_ch_arbiter
  import dmac_pkg::*;
#(
  parameter int unsigned NUM_CH   = 6,
  parameter int unsigned ID_W     = $clog2(NUM_CH),
  parameter int unsigned HOLD_MAX = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic              mode,
  input  logic              arb_en,
  input  logic              xfer_done,
  output logic              grant_valid,
  output logic [ID_W-1:0]   grant_ch,
  output logic [NUM_CH-1:0] grant_onehot,
  output logic              hold_timeout
);

  // Counter only needs to reach HOLD_MAX-1.
  localparam int unsigned CNT_W       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int unsigned HOLD_LAST_I = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_LAST_I[CNT_W-1:0];
  localparam bit TIMEOUT_EN = (HOLD_MAX != 0);

  dmac_state_e       r_state;
  logic              r_armed;
  logic [ID_W-1:0]   r_grant_ch;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]  r_hold_cnt;

  logic [ID_W-1:0]   w_start;
  logic [ID_W-1:0]   w_pick_idx;
  logic              w_pick_found;
  logic              w_busy;
  logic              w_win;
  logic              w_done;
  logic              w_timeout;
  logic              w_release;
  logic [ID_W-1:0]   w_next_ptr;

  // Fixed mode searches from channel 0; round-robin from the rotating pointer.
  always_comb begin
    w_start = (mode == MODE_RR) ? r_rr_ptr : '0;
  end

  dmac_rr_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .req       (ch_req),
    .start_ptr (w_start),
    .index     (w_pick_idx),
    .found     (w_pick_found)
  );

  // Grant, release and timeout qualifiers for the current cycle.
  always_comb begin
    w_busy     = (r_state == BUSY);
    // r_armed delays the first grant to the second edge after reset release.
    w_win      = (r_state == IDLE) && r_armed && arb_en && w_pick_found;
    w_done     = w_busy && xfer_done;
    // A coincident xfer_done wins over expiry, so the release counts as normal.
    w_timeout  = w_busy && TIMEOUT_EN && (r_hold_cnt == HOLD_LAST) && !xfer_done;
    w_release  = w_done || w_timeout;
    w_next_ptr = ID_W'(wrap_inc(32'(r_grant_ch), NUM_CH));
  end

  // FSM, granted channel and rotating pointer; grant_ch is cleared when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_armed    <= 1'b0;
      r_grant_ch <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_win) begin
        r_state    <= BUSY;
        r_grant_ch <= w_pick_idx;
      end else if (w_release) begin
        r_state    <= IDLE;
        r_grant_ch <= '0;
        r_rr_ptr   <= w_next_ptr;
      end
    end
  end

  // Hold counter: cleared on entry to BUSY, counts each BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (w_win || w_release) begin
      r_hold_cnt <= '0;
    end else if (w_busy) begin
      r_hold_cnt <= r_hold_cnt + CNT_W'(1);
    end
  end

  // Output decode; the one-hot vector is forced to zero outside BUSY.
  always_comb begin
    grant_valid  = w_busy;
    grant_ch     = r_grant_ch;
    grant_onehot = w_busy ? (NUM_CH'(1) << r_grant_ch) : '0;
    hold_timeout = w_timeout;
  end

  // Internal sanity checks on the grant outputs.
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_onehot));
  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
                             (w_busy && !w_release) |=> (grant_valid && $stable(grant_ch)));

endmodule

// File: tb/tb_dmac_ch_arbiter.sv
// Scoreboard bench for dmac_ch_arbiter: the driver predicts each grant from
// the arbitration rules and queues it; a negedge monitor checks what appears.
module tb_dmac_ch_arbiter;

  localparam int NCH  = 6;
  localparam int HMAX = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] ch_req;
  logic           mode;
  logic           arb_en;
  logic           xfer_done;
  logic           grant_valid;
  logic [2:0]     grant_ch;
  logic [NCH-1:0] grant_onehot;
  logic           hold_timeout;

  dmac_ch_arbiter #(
    .NUM_CH   (NCH),
    .HOLD_MAX (HMAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_req       (ch_req),
    .mode         (mode),
    .arb_en       (arb_en),
    .xfer_done    (xfer_done),
    .grant_valid  (grant_valid),
    .grant_ch     (grant_ch),
    .grant_onehot (grant_onehot),
    .hold_timeout (hold_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int len;
    bit tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   mptr     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // First requester at or above start, wrapping around the ring.
  function automatic int ref_pick(input logic [NCH-1:0] req, input int start);
    logic [2*NCH-1:0] dbl;
    dbl = {req, req} >> start;
    for (int i = 0; i < NCH; i++) begin
      if (dbl[i]) return (start + i) % NCH;
    end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  bit   in_busy = 1'b0;
  int   kcyc    = 0;
  exp_t cur     = '{ch: 0, len: 0, tmo: 1'b0};

  always @(negedge clk) begin
    logic [NCH-1:0] exp_oh;
    if (!rst_n) begin
      in_busy = 1'b0;
      check("rst_valid", 32'(grant_valid), 0);
      check("rst_ch", 32'(grant_ch), 0);
      check("rst_onehot", 32'(grant_onehot), 0);
      check("rst_timeout", 32'(hold_timeout), 0);
    end else if (grant_valid) begin
      if (!in_busy) begin
        check("grant_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        else cur = '{ch: 0, len: 0, tmo: 1'b0};
        exp_oh = NCH'(1) << cur.ch;
        check("grant_ch", 32'(grant_ch), 32'(cur.ch));
        check("grant_onehot", 32'(grant_onehot), 32'(exp_oh));
        in_busy = 1'b1;
        kcyc    = 1;
      end else begin
        kcyc++;
        check("grant_stable", 32'(grant_ch), 32'(cur.ch));
      end
      check("hold_timeout", 32'(hold_timeout), 32'(cur.tmo && (kcyc == cur.len)));
    end else begin
      if (in_busy) begin
        check("grant_len", 32'(kcyc), 32'(cur.len));
        in_busy = 1'b0;
      end
      check("idle_ch", 32'(grant_ch), 0);
      check("idle_onehot", 32'(grant_onehot), 0);
      check("idle_timeout", 32'(hold_timeout), 0);
    end
  end

  // ---------------- driver ----------------
  // One grant: done_at in 1..HMAX pulses xfer_done in that BUSY cycle,
  // anything else lets the hold timer expire.
  task automatic txn(input logic [NCH-1:0] req, input logic m, input int done_at,
                     input bit after_rst, input bit quiet_busy);
    exp_t e;
    e.ch = ref_pick(req, m ? mptr : 0);
    if (done_at >= 1 && done_at <= HMAX) begin
      e.len = done_at;
      e.tmo = 1'b0;
    end else begin
      e.len = HMAX;
      e.tmo = 1'b1;
    end
    exp_q.push_back(e);
    mptr = (e.ch + 1) % NCH;
    ch_req    = req;
    mode      = m;
    arb_en    = 1'b1;
    xfer_done = 1'b0;
    if (after_rst) begin
      @(posedge clk); #1;
      check("no_grant_first_edge", 32'(grant_valid), 0);
    end
    @(posedge clk); #1;
    for (int k2 = 1; k2 <= e.len; k2++) begin
      if (quiet_busy) begin
        ch_req = '0;
        arb_en = 1'b0;
      end else begin
        ch_req = NCH'($urandom);
        mode   = 1'($urandom);
        arb_en = 1'($urandom);
      end
      xfer_done = (k2 == done_at);
      @(posedge clk); #1;
    end
    xfer_done = 1'b0;
    arb_en    = 1'b0;
  endtask

  // Idle stretch with arbitration disabled; stray xfer_done pulses must be ignored.
  task automatic gap(input int n, input logic [NCH-1:0] req);
    for (int i = 0; i < n; i++) begin
      arb_en    = 1'b0;
      ch_req    = req;
      mode      = 1'($urandom);
      xfer_done = 1'($urandom);
      @(posedge clk); #1;
    end
    xfer_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(grant_valid), 0);
    check("async_rst_ch", 32'(grant_ch), 0);
    check("async_rst_onehot", 32'(grant_onehot), 0);
    check("async_rst_timeout", 32'(hold_timeout), 0);
    ch_req    = '0;
    arb_en    = 1'b0;
    xfer_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mptr  = 0;
  endtask

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    ch_req    = '0;
    mode      = 1'b0;
    arb_en    = 1'b0;
    xfer_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin sweep from a fresh pointer: 0,1,2,3,4,5,0.
    txn(6'b111111, 1'b1, 2, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) txn(6'b111111, 1'b1, 2, 1'b0, 1'b0);

    // Fixed priority picks the lowest set bit.
    txn(6'b101100, 1'b0, 3, 1'b0, 1'b0);

    // Timeout on ch 3, then round-robin must resume at 4.
    txn(6'b001000, 1'b0, 0, 1'b0, 1'b0);
    txn(6'b111111, 1'b1, 1, 1'b0, 1'b0);

    // xfer_done on the expiry cycle is a normal release.
    txn(6'b000010, 1'b0, HMAX, 1'b0, 1'b0);

    // Request and enable drop while granted; then no grant with arb_en low.
    txn(6'b000010, 1'b0, 3, 1'b0, 1'b1);
    gap(4, 6'b111111);

    // Mode switch applies at the next decision.
    txn(6'b000011, 1'b1, 2, 1'b0, 1'b0);
    txn(6'b000011, 1'b0, 2, 1'b0, 1'b0);

    // Reset in the middle of a grant on ch 5.
    e = '{ch: 5, len: HMAX, tmo: 1'b0};
    exp_q.push_back(e);
    ch_req = 6'b100000;
    mode   = 1'b0;
    arb_en = 1'b1;
    @(posedge clk); #1;
    arb_en = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_grant", 32'(grant_valid), 1);
    do_reset();
    txn(6'b100001, 1'b1, 2, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) gap($urandom_range(1, 3), NCH'($urandom));
      txn(NCH'($urandom_range(1, (1 << NCH) - 1)), 1'($urandom), $urandom_range(0, HMAX + 2),
          1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
